dcache_uncached_responder: RTL

- Responder end of the EX-stage data-access interface (valid/op/addr/wdata/wstrb); the ALU stage is the initiator.
- Serves uncached accesses. Stores retire through a small store buffer; loads are issued after the buffer drains.
- Drives a single-outstanding SRAM-like bus (req/addr_ok/data_ok) toward the AXI bridge.
- Returns the raw 32-bit load word to the MEM stage, plus a stall indication for ctrl.

---
 rtl/dcache_uncached_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dcache_uncached_responder.sv
// Uncached data-access responder: buffers stores, issues loads after the buffer
// drains, and drives a single-outstanding SRAM-like bus toward the AXI bridge.
module dcache_uncached_responder #(
  parameter int SB_DEPTH = 2,
  parameter int SB_PTR_W = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic        op_i,
  input  logic [31:0] virtual_addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        bus_addr_ok_i,
  input  logic        bus_data_ok_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT} state_t;

  localparam logic [SB_PTR_W:0] LP_SB_FULL = (SB_PTR_W+1)'(SB_DEPTH);

  state_t              r_state;
  logic [31:0]         r_sb_addr  [SB_DEPTH];
  logic [31:0]         r_sb_wdata [SB_DEPTH];
  logic [3:0]          r_sb_wstrb [SB_DEPTH];
  logic [SB_PTR_W-1:0] r_head, r_tail;
  logic [SB_PTR_W:0]   r_count;
  logic [31:0]         r_ld_addr, r_rdata;
  logic                r_data_ok, r_cancel;

  logic              w_in_wr, w_in_rd, w_pop, w_rd_done, w_cancel;
  logic              w_st_accept, w_ld_accept, w_accept;
  logic [SB_PTR_W:0] w_count_next;

  assign w_in_wr   = (r_state == S_WR_REQ) || (r_state == S_WR_WAIT);
  assign w_in_rd   = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
  // A write (or read) completes in *_REQ only when addr_ok and data_ok coincide.
  assign w_pop     = bus_data_ok_i && ((r_state == S_WR_WAIT) ||
                                       (r_state == S_WR_REQ && bus_addr_ok_i));
  assign w_rd_done = bus_data_ok_i && ((r_state == S_RD_WAIT) ||
                                       (r_state == S_RD_REQ && bus_addr_ok_i));
  assign w_cancel  = r_cancel || flush_i;

  assign w_st_accept = valid_i && op_i && ((r_count != LP_SB_FULL) || w_pop);
  assign w_ld_accept = valid_i && !op_i && (r_state == S_IDLE) &&
                       (r_count == '0) && !w_pop;
  assign w_accept    = w_st_accept || w_ld_accept;

  // NOTE: reset also gates the combinational handshake outputs so every output reads 0 in reset.
  assign addr_ok_o = rst && w_accept;
  assign busy_o    = rst && ((valid_i && !w_accept) || (w_in_rd && !w_cancel));
  assign data_ok_o = r_data_ok;
  assign rdata_o   = r_rdata;

  assign bus_req_o   = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
  assign bus_we_o    = w_in_wr;
  assign bus_addr_o  = w_in_wr ? r_sb_addr[r_head] : (w_in_rd ? r_ld_addr : '0);
  assign bus_wdata_o = w_in_wr ? r_sb_wdata[r_head] : '0;
  assign bus_wstrb_o = w_in_wr ? r_sb_wstrb[r_head] : '0;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    if (w_st_accept && !w_pop)      w_count_next = r_count + (SB_PTR_W+1)'(1);
    else if (!w_st_accept && w_pop) w_count_next = r_count - (SB_PTR_W+1)'(1);
  end

  // NOTE: store-buffer storage has no reset; the count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (w_st_accept) begin
      r_sb_addr[r_tail]  <= virtual_addr_i;
      r_sb_wdata[r_tail] <= wdata_i;
      r_sb_wstrb[r_tail] <= wstrb_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_st_accept) r_tail <= r_tail + SB_PTR_W'(1);
      if (w_pop)       r_head <= r_head + SB_PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ld_addr <= '0;
      r_rdata   <= '0;
      r_data_ok <= 1'b0;
      r_cancel  <= 1'b0;
    end else begin
      r_data_ok <= w_st_accept;
      case (r_state)
        S_IDLE: begin
          r_cancel <= 1'b0;
          if (w_ld_accept) begin
            r_ld_addr <= {virtual_addr_i[31:2], 2'b00};
            r_state   <= S_RD_REQ;
          end else if (r_count != '0) begin
            r_state <= S_WR_REQ;
          end
        end
        S_WR_REQ, S_WR_WAIT: begin
          if (w_pop)
            r_state <= (w_count_next != '0) ? S_WR_REQ : S_IDLE;
          else if (r_state == S_WR_REQ && bus_addr_ok_i)
            r_state <= S_WR_WAIT;
        end
        S_RD_REQ, S_RD_WAIT: begin
          if (w_rd_done) begin
            // A flush arriving with the bus response still cancels it.
            if (!w_cancel) begin
              r_rdata   <= bus_rdata_i;
              r_data_ok <= 1'b1;
            end
            r_cancel <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            if (flush_i) r_cancel <= 1'b1;
            if (r_state == S_RD_REQ && bus_addr_ok_i) r_state <= S_RD_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
